// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one pipelined 64-bit parity checker between two requesters,
// with saturating per-requester error counts and consecutive-error lockout.
module parity_check_arbiter #(
  parameter int CNT_WIDTH   = 16,
  parameter int LOCK_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           reqValid,
  output logic [1:0]           reqReady,
  input  logic [63:0]          reqData0,
  input  logic [63:0]          reqData1,
  input  logic [1:0]           reqEvenParity,
  input  logic [1:0]           reqOddParity,
  output logic                 resValid,
  input  logic                 resReady,
  output logic                 resId,
  output logic                 isErrorEven,
  output logic                 isErrorOdd,
  output logic [CNT_WIDTH-1:0] errCount0,
  output logic [CNT_WIDTH-1:0] errCount1,
  output logic [1:0]           locked,
  input  logic [1:0]           clearLock
);

  typedef enum logic [1:0] {IDLE, CHECK, RESPOND} state_t;

  localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);

  state_t               state_q, state_d;
  logic [63:0]          data_q, data_d;
  logic                 even_q, even_d;
  logic                 odd_q, odd_d;
  logic                 id_q, id_d;
  logic                 err_even_q, err_even_d;
  logic                 err_odd_q, err_odd_d;
  logic                 res_valid_q, res_valid_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] err_cnt_q [2];
  logic [CNT_WIDTH-1:0] err_cnt_d [2];
  logic [3:0]           consec_q [2];
  logic [3:0]           consec_d [2];
  logic [1:0]           locked_q, locked_d;

  logic [1:0] eligible;
  logic       grant_any;
  logic       grant_id;
  logic       commit;
  logic       parity;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    eligible  = reqValid & ~locked_q;
    grant_any = |eligible;
    grant_id  = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
    reqReady  = 2'b00;
    if (state_q == IDLE && grant_any && !reset) begin
      reqReady = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    even_d       = even_q;
    odd_d        = odd_q;
    id_d         = id_q;
    err_even_d   = err_even_q;
    err_odd_d    = err_odd_q;
    res_valid_d  = res_valid_q;
    last_grant_d = last_grant_q;
    err_cnt_d    = err_cnt_q;
    consec_d     = consec_q;
    locked_d     = locked_q;
    parity       = ^data_q;
    commit       = res_valid_q & resReady;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          data_d  = grant_id ? reqData1 : reqData0;
          even_d  = reqEvenParity[grant_id];
          odd_d   = reqOddParity[grant_id];
          id_d    = grant_id;
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_even_d  = parity ^ even_q;
        err_odd_d   = ~(parity ^ odd_q);
        res_valid_d = 1'b1;
        state_d     = RESPOND;
      end
      RESPOND: begin
        if (commit) begin
          res_valid_d  = 1'b0;
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // clearLock is applied last so it overrides a lock from a coincident commit.
    for (int i = 0; i < 2; i++) begin
      if (commit && id_q == 1'(i)) begin
        if (err_even_q || err_odd_q) begin
          if (err_cnt_q[i] != '1) err_cnt_d[i] = err_cnt_q[i] + CNT_WIDTH'(1);
          if (consec_q[i] != 4'hF) consec_d[i] = consec_q[i] + 4'd1;
          if (consec_q[i] >= LOCK_T - 4'd1) locked_d[i] = 1'b1;
        end else begin
          consec_d[i] = '0;
        end
      end
      if (clearLock[i]) begin
        locked_d[i] = 1'b0;
        consec_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      even_q       <= 1'b0;
      odd_q        <= 1'b0;
      id_q         <= 1'b0;
      err_even_q   <= 1'b0;
      err_odd_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
      err_cnt_q[0] <= '0;
      err_cnt_q[1] <= '0;
      consec_q[0]  <= '0;
      consec_q[1]  <= '0;
      locked_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      even_q       <= even_d;
      odd_q        <= odd_d;
      id_q         <= id_d;
      err_even_q   <= err_even_d;
      err_odd_q    <= err_odd_d;
      res_valid_q  <= res_valid_d;
      last_grant_q <= last_grant_d;
      err_cnt_q    <= err_cnt_d;
      consec_q     <= consec_d;
      locked_q     <= locked_d;
    end
  end

  assign resValid    = res_valid_q;
  assign resId       = id_q;
  assign isErrorEven = err_even_q;
  assign isErrorOdd  = err_odd_q;
  assign errCount0   = err_cnt_q[0];
  assign errCount1   = err_cnt_q[1];
  assign locked      = locked_q;

endmodule
